// File: rtl/card_pkg.sv
// Shared definitions for the card dealer: FSM encoding, deck geometry and
// the deck-index to rank mapping.
package card_pkg;

  localparam int              DECK_SIZE    = 52;
  localparam int              RANK_W       = 4;
  localparam int              IDX_W        = 6;
  localparam int              RANK_MAX     = 13;
  localparam logic [15:0]     DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    PROBE = 2'd2,
    EMIT  = 2'd3
  } state_e;

  // Four consecutive indices share a rank: index i -> rank i[5:2]+1.
  function automatic logic [RANK_W-1:0] rank_of(input logic [IDX_W-1:0] idx);
    return idx[5:2] + 4'd1;
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Fibonacci LFSR (taps 16,14,13,11) with a zero-lock guard.
module card_lfsr #(
  parameter int LFSR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_q;
  logic              fb;

  assign fb = q_q[LFSR_W-1] ^ q_q[LFSR_W-3] ^ q_q[LFSR_W-4] ^ q_q[LFSR_W-6];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= seed;
    end else if (q_q == '0) begin
      q_q <= seed;
    end else begin
      q_q <= {q_q[LFSR_W-2:0], fb};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/card_dealer.sv
// Deals ranks 1..13 from a 52-card deck without replacement, one card per
// accepted pip, using an LFSR pick followed by a linear probe for a free slot.
module card_dealer #(
  parameter int          DECK_SIZE = 52,
  parameter int          LFSR_W    = 16,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pip,
  input  logic       shuffle,
  output logic [3:0] number,
  output logic       valid,
  output logic       busy,
  output logic       empty,
  output logic       err,
  output logic [5:0] cards_left
);

  import card_pkg::*;

  localparam logic [LFSR_W-1:0] EFF_SEED  = (SEED == '0) ? LFSR_W'(DEFAULT_SEED)
                                                         : LFSR_W'(SEED);
  localparam logic [IDX_W-1:0]  DECK_N    = IDX_W'(DECK_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DECK_SIZE - 1);

  state_e                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic [DECK_SIZE-1:0]   used_q;
  logic [IDX_W-1:0]       left_q;
  logic [RANK_W-1:0]      number_q;
  logic                   valid_q;
  logic                   err_q;

  logic [LFSR_W-1:0]      lfsr;
  logic [IDX_W-1:0]       pick_raw;
  logic [IDX_W-1:0]       pick_idx;
  logic                   lfsr_unused;

  card_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (EFF_SEED),
    .q     (lfsr)
  );

  // Only the low six bits choose a slot; values 52..63 fold back onto 0..11.
  assign pick_raw    = lfsr[IDX_W-1:0];
  assign pick_idx    = (pick_raw < DECK_N) ? pick_raw : pick_raw - DECK_N;
  assign lfsr_unused = ^lfsr[LFSR_W-1:IDX_W];

  // NOTE: the used bitmap is plain flops, not a RAM, so it is cleared by
  // reset and by shuffle in a single edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      used_q   <= '0;
      left_q   <= DECK_N;
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      number_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      if (shuffle) begin
        used_q  <= '0;
        left_q  <= DECK_N;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (pip) begin
              if (left_q == '0) err_q   <= 1'b1;
              else              state_q <= PICK;
            end
          end
          PICK: begin
            idx_q   <= pick_idx;
            state_q <= PROBE;
          end
          PROBE: begin
            if (!used_q[idx_q]) begin
              used_q[idx_q] <= 1'b1;
              left_q        <= left_q - 6'd1;
              number_q      <= rank_of(idx_q);
              valid_q       <= 1'b1;
              state_q       <= EMIT;
            end else begin
              idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 6'd1;
            end
          end
          EMIT: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign number     = number_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign cards_left = left_q;
  assign empty      = (left_q == '0);

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer; an independent LFSR/deck model predicts
// the rank and probe latency of every deal.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pip = 1'b0;
  logic       shuffle = 1'b0;
  logic [3:0] number;
  logic       valid;
  logic       busy;
  logic       empty;
  logic       err;
  logic [5:0] cards_left;

  int total = 0;
  int bad   = 0;

  logic [15:0] lfsr_m;
  logic [51:0] used_m = '0;
  int          rank_cnt [14];

  always #5 clk = ~clk;

  card_dealer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pip        (pip),
    .shuffle    (shuffle),
    .number     (number),
    .valid      (valid),
    .busy       (busy),
    .empty      (empty),
    .err        (err),
    .cards_left (cards_left)
  );

  // Reference LFSR: Fibonacci, taps 16,14,13,11, shifting every edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= 16'hACE1;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One deal. With busy_pips set, pip is also held high through the PICK
  // and PROBE cycles, which must be ignored.
  task automatic deal(input bit busy_pips);
    logic [15:0] l;
    int idx, p, n, exp_rank;
    bit stray;
    @(negedge clk) pip = 1'b1;
    @(posedge clk);
    #1 l = lfsr_m;
    @(negedge clk) pip = busy_pips;
    idx = int'(l[5:0]);
    if (idx >= 52) idx -= 52;
    p = 0;
    while (used_m[idx]) begin
      idx = (idx == 51) ? 0 : idx + 1;
      p++;
    end
    used_m[idx] = 1'b1;
    exp_rank = idx / 4 + 1;
    rank_cnt[exp_rank]++;
    check("busy_after_pip", 16'(busy), 16'd1);
    n = 0;
    stray = 1'b0;
    while (valid !== 1'b1 && n < 60) begin
      if (number !== 4'd0) stray = 1'b1;
      @(negedge clk);
      n++;
      if (n >= 2) pip = 1'b0;
    end
    pip = 1'b0;
    check("deal_latency", 16'(n), 16'(2 + p));
    check("deal_rank", 16'(number), 16'(exp_rank));
    check("number_zero_before_valid", 16'(stray), 16'd0);
    @(negedge clk);
    check("valid_one_cycle", 16'({valid, number, busy}), 16'd0);
  endtask

  task automatic watch_no_valid(input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid !== 1'b0 || number !== 4'd0) seen = 1'b1;
    end
    check("no_valid_window", 16'(seen), 16'd0);
  endtask

  initial begin
    for (int r = 0; r < 14; r++) rank_cnt[r] = 0;

    // Reset state, held stable for 10 idle cycles.
    #12 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_outputs", 16'({number, valid, busy, empty, err}), 16'd0);
      check("reset_cards_left", 16'(cards_left), 16'd52);
    end

    // Single deal.
    deal(1'b0);
    check("left_after_one", 16'(cards_left), 16'd51);

    // Rest of the deck.
    for (int d = 0; d < 51; d++) deal(1'b0);
    check("left_after_52", 16'(cards_left), 16'd0);
    check("empty_after_52", 16'(empty), 16'd1);
    for (int r = 1; r <= 13; r++) check($sformatf("rank_%0d_count", r), 16'(rank_cnt[r]), 16'd4);

    // 53rd pip on an empty deck.
    @(negedge clk) pip = 1'b1;
    @(negedge clk) pip = 1'b0;
    check("err_on_empty", 16'(err), 16'd1);
    check("no_deal_on_empty", 16'({valid, number, busy}), 16'd0);
    @(negedge clk);
    check("err_one_cycle", 16'(err), 16'd0);
    watch_no_valid(4);

    // Shuffle restores the deck.
    @(negedge clk) shuffle = 1'b1;
    @(negedge clk) shuffle = 1'b0;
    used_m = '0;
    check("left_after_shuffle", 16'(cards_left), 16'd52);
    check("empty_after_shuffle", 16'(empty), 16'd0);

    // pip and shuffle together: shuffle wins.
    @(negedge clk) begin pip = 1'b1; shuffle = 1'b1; end
    @(negedge clk) begin pip = 1'b0; shuffle = 1'b0; end
    check("pip_shuffle_not_busy", 16'(busy), 16'd0);
    watch_no_valid(6);
    check("pip_shuffle_left", 16'(cards_left), 16'd52);

    // Shuffle while in PROBE aborts the deal.
    @(negedge clk) pip = 1'b1;
    @(negedge clk) pip = 1'b0;
    @(negedge clk) shuffle = 1'b1;
    @(negedge clk) shuffle = 1'b0;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_left", 16'(cards_left), 16'd52);
    watch_no_valid(6);

    // pips while busy are dropped.
    deal(1'b1);
    watch_no_valid(6);
    check("busy_pips_left", 16'(cards_left), 16'd51);

    // Async reset mid-deal.
    @(negedge clk) pip = 1'b1;
    @(negedge clk) pip = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 16'({number, valid, busy, err}), 16'd0);
    check("async_reset_left", 16'(cards_left), 16'd52);
    @(negedge clk) rst_n = 1'b1;
    used_m = '0;
    watch_no_valid(3);

    // Deal after reset stays in step with the model.
    deal(1'b0);
    check("left_after_reset_deal", 16'(cards_left), 16'd51);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
